// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment reader.
//   - Active-low glyph constants for hex digits 0..F (bit0 = a .. bit6 = g)
//   - SEG_BLANK: all segments off
//   - seg_state_t: reader FSM state encoding
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seg_state_t;

endpackage

// File: rtl/seg_pattern_lut.sv
// seg_pattern_lut: combinational decode of an active-low segment pattern.
// Ports:
//   seg_in [6:0]  in   active-low segment pattern
//   legal         out  pattern is one of the 16 hex glyphs
//   blank         out  pattern is all segments off
//   digit [3:0]   out  decoded hex value (0 when not legal)
module seg_pattern_lut
    import seg_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic       legal,
    output logic       blank,
    output logic [3:0] digit
);

    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        digit = 4'h0;
        case (seg_in)
            SEG_0: digit = 4'h0;
            SEG_1: digit = 4'h1;
            SEG_2: digit = 4'h2;
            SEG_3: digit = 4'h3;
            SEG_4: digit = 4'h4;
            SEG_5: digit = 4'h5;
            SEG_6: digit = 4'h6;
            SEG_7: digit = 4'h7;
            SEG_8: digit = 4'h8;
            SEG_9: digit = 4'h9;
            SEG_A: digit = 4'hA;
            SEG_B: digit = 4'hB;
            SEG_C: digit = 4'hC;
            SEG_D: digit = 4'hD;
            SEG_E: digit = 4'hE;
            SEG_F: digit = 4'hF;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// seg_reader: debounces a seven-segment pattern, decodes it to a hex digit
// and offers the result through a one-entry valid/ready output register.
// Optional build macro SEG_READER_ERRCNT_EN adds the err_count output.
// Ports:
//   clk, resetn         clock, async active-low reset
//   seg_in, seg_valid   sampled segment pattern and its qualifier
//   out_valid/out_ready downstream handshake for digit/err
//   digit, err          decoded value, illegal-glyph flag
//   overflow, clr_ovf   sticky dropped-result flag and its clear
//   err_count           (macro only) saturating count of emitted err results
//
// state  | meaning
// IDLE   | no valid input, nothing captured
// SETTLE | pattern captured, counting identical consecutive samples
// HOLD   | pattern accepted, waiting for it to change or go invalid
module seg_reader
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] seg_in,
    input  logic       seg_valid,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] digit,
    output logic       err,
    input  logic       clr_ovf,
    output logic       overflow
`ifdef SEG_READER_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [7:0] STABLE_TC = 8'(STABLE_CYCLES);

    seg_state_t state_q, state_d;
    logic [6:0] cap_q, cap_d;
    logic [7:0] cnt_q, cnt_d;
    logic       accept;

    logic       lut_legal;
    logic       lut_blank;
    logic [3:0] lut_digit;

    // At acceptance the current sample always equals the capture, so decode seg_in.
    seg_pattern_lut u_lut (
        .seg_in (seg_in),
        .legal  (lut_legal),
        .blank  (lut_blank),
        .digit  (lut_digit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cap_q   <= 7'h00;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (seg_valid) begin
                    cap_d   = seg_in;
                    cnt_d   = 8'd1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!seg_valid) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (seg_in != cap_q) begin
                    cap_d = seg_in;
                    cnt_d = 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (!seg_valid) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (seg_in != cap_q) begin
                    cap_d   = seg_in;
                    cnt_d   = 8'd1;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
        // Shared terminal-count check so a fresh capture can accept at once
        // when only one stable sample is required.
        if (state_d == ST_SETTLE && cnt_d == STABLE_TC) begin
            accept  = 1'b1;
            state_d = ST_HOLD;
        end
    end

    logic handshake, emit, load, drop;

    assign handshake = out_valid & out_ready;
    assign emit      = accept & ~lut_blank;
    assign load      = emit & (~out_valid | handshake);
    assign drop      = emit & out_valid & ~out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            digit     <= 4'h0;
            err       <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            digit     <= lut_digit;
            err       <= ~lut_legal;
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef SEG_READER_ERRCNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_count <= 8'd0;
        end else if (clr_ovf) begin
            err_count <= 8'd0;
        end else if (load && !lut_legal && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
